// File: rtl/mat_mul_gen_pkg.sv
// Shared definitions for the matrix-multiply accelerator: FSM states,
// flush length and the helpers that turn DIM_LOG into matrix sizes.
package mat_mul_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_FLUSH   = 2'd2,
      S_XFER    = 2'd3
   } state_t;

   // Cycles spent draining the read/MAC pipeline before results are streamed
   localparam int FLUSH_CYCLES = 2;

   function automatic int dim_of(input int dim_log);
      return 1 << dim_log;
   endfunction

   function automatic int size_of(input int dim_log);
      return dim_of(dim_log) * dim_of(dim_log);
   endfunction

endpackage

// File: rtl/mat_mul_mac.sv
// Multiply-accumulate unit: sign- or zero-extends each product into a wide
// wrapping accumulator and presents the running sum, saturated or truncated
// to the element width, as the result.
module mat_mul_mac
   import mat_mul_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 64
)
(
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_areset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  last,
   input  logic                  signed_mode,
   input  logic                  sat_en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int EW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

   logic [ACC_WIDTH-1:0] acc;
   logic [PW-1:0]        a_ext;
   logic [PW-1:0]        b_ext;
   logic [PW-1:0]        prod;
   logic [EW-1:0]        prod_wide;
   logic [ACC_WIDTH-1:0] prod_acc;
   logic [ACC_WIDTH-1:0] sum;
   logic [ACC_WIDTH-1:0] sum_hi_s;
   logic [ACC_WIDTH-1:0] sum_hi_u;

   // Full-width product of the extended operands, then extended into the accumulator width
   always_comb begin
      a_ext     = {{DATA_WIDTH{signed_mode & a[DATA_WIDTH-1]}}, a};
      b_ext     = {{DATA_WIDTH{signed_mode & b[DATA_WIDTH-1]}}, b};
      prod      = a_ext * b_ext;
      prod_wide = {EW{signed_mode & prod[PW-1]}};
      prod_wide[PW-1:0] = prod;
      prod_acc  = prod_wide[ACC_WIDTH-1:0];
      sum       = acc + prod_acc;
   end

   // Clamp the running sum to the element range when saturating, otherwise keep the low bits
   always_comb begin
      sum_hi_s = ACC_WIDTH'($signed(sum) >>> (DATA_WIDTH - 1));
      sum_hi_u = sum >> DATA_WIDTH;
      result   = sum[DATA_WIDTH-1:0];
      if (sat_en) begin
         if (signed_mode) begin
            if ((sum_hi_s != '0) && (sum_hi_s != '1)) begin
               result = sum[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
         end else if (sum_hi_u != '0) begin
            result = '1;
         end
      end
   end

   // Accumulator restarts at zero once a dot product has been handed off
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset || clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= last ? '0 : sum;
      end
   end

endmodule

// File: rtl/mat_mul_gen.sv
// Matrix-multiply accelerator top: loads A and B from the input stream,
// computes R = A * B one inner-product term per cycle, then streams R out
// through a two-entry read-ahead buffer with full backpressure.
module mat_mul_gen
   import mat_mul_gen_pkg::*;
#(
   parameter int DIM_LOG    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 64
)
(
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_areset,
   output logic                    s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                    s00_axis_tlast,
   input  logic                    s00_axis_tvalid,
   output logic                    m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   input  logic                    sel,
   input  logic                    start,
   input  logic [DIM_LOG-1:0]      dim_m,
   input  logic [DIM_LOG-1:0]      dim_k,
   input  logic [DIM_LOG-1:0]      dim_n,
   input  logic                    signed_mode,
   input  logic                    sat_en,
   output logic                    busy
);

   localparam int SIZE   = size_of(DIM_LOG);
   localparam int ADDR_W = 2 * DIM_LOG;
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

   state_t state;

   logic [DATA_WIDTH-1:0] ram_a [SIZE];
   logic [DATA_WIDTH-1:0] ram_b [SIZE];
   logic [DATA_WIDTH-1:0] ram_r [SIZE];

   logic [CNT_W-1:0]   addr_in;
   logic [DIM_LOG-1:0] m_lat, k_lat, n_lat;
   logic [DIM_LOG-1:0] i_cnt, j_cnt, k_cnt;
   logic               signed_lat, sat_lat;
   logic [ADDR_W-1:0]  stride_a, stride_b;
   logic [CNT_W-1:0]   total_beats;
   logic [CNT_W-1:0]   addr_r;
   logic [1:0]         flush_cnt;

   logic [ADDR_W-1:0]  a_rd_addr, b_rd_addr, r_dst_addr;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic               p_valid, p_last;
   logic [ADDR_W-1:0]  p_raddr;
   logic [DATA_WIDTH-1:0] mac_result;

   logic [DATA_WIDTH-1:0] obuf_data [2];
   logic [1:0]         obuf_last;
   logic               wr_idx, rd_idx;
   logic [1:0]         obuf_count;

   logic in_beat, start_ok, last_k, last_all;
   logic pop, pop_last, issue;

   // Handshake decode and the row-major addresses of the current (i,j,k) term
   always_comb begin
      in_beat    = s00_axis_tvalid && s00_axis_tready;
      start_ok   = start && (state == S_IDLE) && !in_beat;
      last_k     = (k_cnt == k_lat);
      last_all   = last_k && (j_cnt == n_lat) && (i_cnt == m_lat);
      a_rd_addr  = ADDR_W'(i_cnt) * stride_a + ADDR_W'(k_cnt);
      b_rd_addr  = ADDR_W'(k_cnt) * stride_b + ADDR_W'(j_cnt);
      r_dst_addr = ADDR_W'(i_cnt) * stride_b + ADDR_W'(j_cnt);
      m00_axis_tvalid = (obuf_count != 2'd0);
      m00_axis_tdata  = obuf_data[rd_idx];
      m00_axis_tlast  = m00_axis_tvalid && obuf_last[rd_idx];
      m00_axis_tstrb  = '1;
      pop      = m00_axis_tvalid && m00_axis_tready;
      pop_last = pop && obuf_last[rd_idx];
      issue    = (state == S_XFER) && (addr_r < total_beats) &&
                 ((obuf_count != 2'd2) || pop);
   end

   // Control FSM: latches the job on start, walks i/j/k, drains, then streams
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         state           <= S_IDLE;
         busy            <= 1'b0;
         s00_axis_tready <= 1'b1;
         m_lat           <= '0;
         k_lat           <= '0;
         n_lat           <= '0;
         signed_lat      <= 1'b0;
         sat_lat         <= 1'b0;
         stride_a        <= '0;
         stride_b        <= '0;
         total_beats     <= '0;
         i_cnt           <= '0;
         j_cnt           <= '0;
         k_cnt           <= '0;
         flush_cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  m_lat           <= dim_m;
                  k_lat           <= dim_k;
                  n_lat           <= dim_n;
                  signed_lat      <= signed_mode;
                  sat_lat         <= sat_en;
                  stride_a        <= ADDR_W'(dim_k) + ADDR_W'(1);
                  stride_b        <= ADDR_W'(dim_n) + ADDR_W'(1);
                  total_beats     <= (CNT_W'(dim_m) + CNT_W'(1)) * (CNT_W'(dim_n) + CNT_W'(1));
                  i_cnt           <= '0;
                  j_cnt           <= '0;
                  k_cnt           <= '0;
                  state           <= S_COMPUTE;
                  busy            <= 1'b1;
                  s00_axis_tready <= 1'b0;
               end
            end
            S_COMPUTE: begin
               if (last_k) begin
                  k_cnt <= '0;
                  if (j_cnt == n_lat) begin
                     j_cnt <= '0;
                     if (i_cnt == m_lat) begin
                        i_cnt     <= '0;
                        flush_cnt <= '0;
                        state     <= S_FLUSH;
                     end else begin
                        i_cnt <= i_cnt + DIM_LOG'(1);
                     end
                  end else begin
                     j_cnt <= j_cnt + DIM_LOG'(1);
                  end
               end else begin
                  k_cnt <= k_cnt + DIM_LOG'(1);
               end
               if (last_all) begin
                  state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == 2'(FLUSH_CYCLES - 1)) begin
                  state <= S_XFER;
               end else begin
                  flush_cnt <= flush_cnt + 2'd1;
               end
            end
            S_XFER: begin
               if (pop_last) begin
                  state           <= S_IDLE;
                  busy            <= 1'b0;
                  s00_axis_tready <= 1'b1;
               end
            end
            default: begin
               state           <= S_IDLE;
               busy            <= 1'b0;
               s00_axis_tready <= 1'b1;
            end
         endcase
      end
   end

   // Load pointer: advances per accepted beat, parks at SIZE, rewinds on tlast
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         addr_in <= '0;
      end else if (in_beat) begin
         if (s00_axis_tlast) begin
            addr_in <= '0;
         end else if (addr_in != SIZE_C) begin
            addr_in <= addr_in + CNT_W'(1);
         end
      end
   end

   // Matrix storage; contents survive reset so a job can be rerun without reloading
   always_ff @(posedge s00_axi_aclk) begin
      if (in_beat && (addr_in < SIZE_C)) begin
         if (sel) begin
            ram_b[addr_in[ADDR_W-1:0]] <= s00_axis_tdata;
         end else begin
            ram_a[addr_in[ADDR_W-1:0]] <= s00_axis_tdata;
         end
      end
      if (p_valid && p_last) begin
         ram_r[p_raddr] <= mac_result;
      end
   end

   // Registered operand read, carrying along the tags the MAC stage needs
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         a_q     <= '0;
         b_q     <= '0;
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         p_raddr <= '0;
      end else begin
         a_q     <= ram_a[a_rd_addr];
         b_q     <= ram_b[b_rd_addr];
         p_valid <= (state == S_COMPUTE);
         p_last  <= last_k;
         p_raddr <= r_dst_addr;
      end
   end

   mat_mul_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .s00_axi_aclk   (s00_axi_aclk),
      .s00_axi_areset (s00_axi_areset),
      .clear          (start_ok),
      .enable         (p_valid),
      .last           (p_last),
      .signed_mode    (signed_lat),
      .sat_en         (sat_lat),
      .a              (a_q),
      .b              (b_q),
      .result         (mac_result)
   );

   // Two-entry read-ahead buffer so a continuously ready sink sees one beat per cycle
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         addr_r       <= '0;
         obuf_data[0] <= '0;
         obuf_data[1] <= '0;
         obuf_last    <= '0;
         wr_idx       <= 1'b0;
         rd_idx       <= 1'b0;
         obuf_count   <= '0;
      end else if (start_ok) begin
         addr_r     <= '0;
         wr_idx     <= 1'b0;
         rd_idx     <= 1'b0;
         obuf_count <= '0;
      end else begin
         if (issue) begin
            obuf_data[wr_idx] <= ram_r[addr_r[ADDR_W-1:0]];
            obuf_last[wr_idx] <= (addr_r == total_beats - CNT_W'(1));
            wr_idx            <= ~wr_idx;
            addr_r            <= addr_r + CNT_W'(1);
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         case ({issue, pop})
            2'b10:   obuf_count <= obuf_count + 2'd1;
            2'b01:   obuf_count <= obuf_count - 2'd1;
            default: obuf_count <= obuf_count;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mul_gen.sv
// Directed bench for mat_mul_gen with a 4x4 maximum size: hand-computed
// products, saturation corners, backpressure, reset and ignored starts.
module tb_mat_mul_gen;

   localparam int DL = 2;
   localparam int DW = 32;
   localparam int AW = 64;

   logic          clk = 1'b0;
   logic          areset;
   logic          s_tready;
   logic [DW-1:0] s_tdata;
   logic          s_tlast;
   logic          s_tvalid;
   logic          m_tvalid;
   logic [DW-1:0] m_tdata;
   logic [DW/8-1:0] m_tstrb;
   logic          m_tlast;
   logic          m_tready;
   logic          sel;
   logic          start;
   logic [DL-1:0] dim_m, dim_k, dim_n;
   logic          signed_mode;
   logic          sat_en;
   logic          busy;

   int errors = 0;
   int checks = 0;

   logic [31:0] load_v   [20];
   logic [31:0] exp_v    [16];
   logic [31:0] got_data [16];
   logic        got_last [16];
   int          got_count;

   always #5 clk = ~clk;

   mat_mul_gen #(
      .DIM_LOG    (DL),
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_areset  (areset),
      .s00_axis_tready (s_tready),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tvalid (s_tvalid),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tready (m_tready),
      .sel             (sel),
      .start           (start),
      .dim_m           (dim_m),
      .dim_k           (dim_k),
      .dim_n           (dim_n),
      .signed_mode     (signed_mode),
      .sat_en          (sat_en),
      .busy            (busy)
   );

   // Single comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Stream the first n entries of load_v into matrix A (0) or B (1)
   task automatic applyStimulus(input logic which, input int n);
      for (int i = 0; i < n; i++) begin
         sel      = which;
         s_tvalid = 1'b1;
         s_tdata  = load_v[i];
         s_tlast  = (i == n - 1);
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Pulse start for one cycle with the given dimensions (minus one) and mode
   task automatic startMul(input int m, input int k, input int n,
                           input logic sgn, input logic sat);
      dim_m       = 2'(m);
      dim_k       = 2'(k);
      dim_n       = 2'(n);
      signed_mode = sgn;
      sat_en      = sat;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   // Collect result beats; pattern 1 gives ready 1,0,0,1,0,0,...; optionally poke start mid-stream
   task automatic collectBeats(input int n_beats, input int pattern, input logic poke_start);
      int   cyc;
      int   cnt;
      logic poked;
      logic stalled;
      logic [31:0] held;
      cyc = 0; cnt = 0; poked = 1'b0; stalled = 1'b0; held = '0;
      while ((cnt < n_beats) && (cyc < 300)) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (stalled) begin
            checkOutput("stall_valid", 32'(m_tvalid), 32'd1);
            checkOutput("stall_data", m_tdata, held);
         end
         m_tready = (pattern == 0) ? 1'b1 : ((cyc % 3) == 1);
         stalled  = 1'b0;
         if (m_tvalid) begin
            if (poke_start && !poked) begin
               start = 1'b1;
               poked = 1'b1;
            end
            if (m_tready) begin
               got_data[cnt] = m_tdata;
               got_last[cnt] = m_tlast;
               cnt++;
            end else begin
               stalled = 1'b1;
               held    = m_tdata;
            end
         end
      end
      got_count = cnt;
      @(negedge clk);
      m_tready = 1'b0;
      start    = 1'b0;
   endtask

   // Compare collected beats against exp_v, with tlast only on the final beat
   task automatic checkResults(input string tag, input int n);
      checkOutput($sformatf("%s_beats", tag), 32'(got_count), 32'(n));
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_v[i]);
         checkOutput($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == n - 1));
      end
   endtask

   // Load the 2x2 pair A={1,2,3,4}, B={5,6,7,8}
   task automatic loadBasic();
      for (int i = 0; i < 4; i++) load_v[i] = 32'(i + 1);
      applyStimulus(1'b0, 4);
      for (int i = 0; i < 4; i++) load_v[i] = 32'(i + 5);
      applyStimulus(1'b1, 4);
   endtask

   task automatic setBasicExp();
      exp_v[0] = 32'd19; exp_v[1] = 32'd22; exp_v[2] = 32'd43; exp_v[3] = 32'd50;
   endtask

   // Safety net in case the design stops responding altogether
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      areset = 1'b1; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
      sel = 1'b0; start = 1'b0; dim_m = '0; dim_k = '0; dim_n = '0;
      signed_mode = 1'b0; sat_en = 1'b0;
      repeat (2) @(negedge clk);
      areset = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
      checkOutput("rst_in_ready", 32'(s_tready), 32'd1);
      checkOutput("rst_strb", 32'(m_tstrb), 32'hF);

      $display("[TB] start alongside an input beat is ignored");
      sel = 1'b0; s_tvalid = 1'b1; s_tdata = 32'd1; s_tlast = 1'b1; start = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0; start = 1'b0;
      checkOutput("start_with_beat_busy", 32'(busy), 32'd0);

      $display("[TB] 2x2x2 unsigned");
      loadBasic();
      startMul(1, 1, 1, 1'b0, 1'b0);
      checkOutput("t1_busy_on", 32'(busy), 32'd1);
      checkOutput("t1_in_ready_off", 32'(s_tready), 32'd0);
      collectBeats(4, 0, 1'b0);
      setBasicExp();
      checkResults("t1", 4);
      checkOutput("t1_busy_off", 32'(busy), 32'd0);
      checkOutput("t1_in_ready_on", 32'(s_tready), 32'd1);

      $display("[TB] 3x2 times 2x4");
      for (int i = 0; i < 6; i++) load_v[i] = 32'(i + 1);
      applyStimulus(1'b0, 6);
      for (int i = 0; i < 8; i++) load_v[i] = 32'(i + 1);
      applyStimulus(1'b1, 8);
      startMul(2, 1, 3, 1'b0, 1'b0);
      collectBeats(12, 0, 1'b0);
      exp_v[0] = 32'd11; exp_v[1] = 32'd14; exp_v[2]  = 32'd17; exp_v[3]  = 32'd20;
      exp_v[4] = 32'd23; exp_v[5] = 32'd30; exp_v[6]  = 32'd37; exp_v[7]  = 32'd44;
      exp_v[8] = 32'd35; exp_v[9] = 32'd46; exp_v[10] = 32'd57; exp_v[11] = 32'd68;
      checkResults("t2", 12);

      $display("[TB] 2x2x2 signed");
      load_v[0] = 32'hFFFFFFFF; load_v[1] = 32'd2; load_v[2] = 32'd3; load_v[3] = 32'hFFFFFFFC;
      applyStimulus(1'b0, 4);
      load_v[0] = 32'd5; load_v[1] = 32'hFFFFFFFA; load_v[2] = 32'd7; load_v[3] = 32'd8;
      applyStimulus(1'b1, 4);
      startMul(1, 1, 1, 1'b1, 1'b0);
      collectBeats(4, 0, 1'b0);
      exp_v[0] = 32'd9; exp_v[1] = 32'd22; exp_v[2] = 32'hFFFFFFF3; exp_v[3] = 32'hFFFFFFCE;
      checkResults("t3", 4);

      $display("[TB] 1x1x1 saturation corners");
      load_v[0] = 32'h7FFFFFFF;
      applyStimulus(1'b0, 1);
      applyStimulus(1'b1, 1);
      startMul(0, 0, 0, 1'b1, 1'b1);
      collectBeats(1, 0, 1'b0);
      exp_v[0] = 32'h7FFFFFFF;
      checkResults("sat_pos", 1);
      startMul(0, 0, 0, 1'b1, 1'b0);
      collectBeats(1, 0, 1'b0);
      exp_v[0] = 32'h00000001;
      checkResults("trunc_pos", 1);
      load_v[0] = 32'h80000000;
      applyStimulus(1'b1, 1);
      startMul(0, 0, 0, 1'b1, 1'b1);
      collectBeats(1, 0, 1'b0);
      exp_v[0] = 32'h80000000;
      checkResults("sat_neg", 1);
      load_v[0] = 32'hFFFFFFFF;
      applyStimulus(1'b0, 1);
      load_v[0] = 32'd2;
      applyStimulus(1'b1, 1);
      startMul(0, 0, 0, 1'b0, 1'b1);
      collectBeats(1, 0, 1'b0);
      exp_v[0] = 32'hFFFFFFFF;
      checkResults("sat_uns", 1);
      startMul(0, 0, 0, 1'b0, 1'b0);
      collectBeats(1, 0, 1'b0);
      exp_v[0] = 32'hFFFFFFFE;
      checkResults("trunc_uns", 1);

      $display("[TB] overlong load drops the extra beat");
      for (int i = 0; i < 16; i++) load_v[i] = 32'(i + 1);
      load_v[16] = 32'd99;
      applyStimulus(1'b0, 17);
      load_v[0] = 32'd3;
      applyStimulus(1'b1, 1);
      startMul(0, 0, 0, 1'b0, 1'b0);
      collectBeats(1, 0, 1'b0);
      exp_v[0] = 32'd3;
      checkResults("drop", 1);

      $display("[TB] 2x2 with stalling sink");
      loadBasic();
      startMul(1, 1, 1, 1'b0, 1'b0);
      collectBeats(4, 1, 1'b0);
      setBasicExp();
      checkResults("stall", 4);
      checkOutput("stall_no_extra", 32'(m_tvalid), 32'd0);

      $display("[TB] reset during compute");
      startMul(1, 1, 1, 1'b0, 1'b0);
      @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("midrst_tlast", 32'(m_tlast), 32'd0);
      checkOutput("midrst_in_ready", 32'(s_tready), 32'd1);
      startMul(1, 1, 1, 1'b0, 1'b0);
      collectBeats(4, 0, 1'b0);
      setBasicExp();
      checkResults("recover", 4);

      $display("[TB] start during transfer is ignored");
      startMul(1, 1, 1, 1'b0, 1'b0);
      collectBeats(4, 0, 1'b1);
      checkResults("xfer_start", 4);
      checkOutput("xfer_start_idle", 32'(busy), 32'd0);
      checkOutput("xfer_start_quiet", 32'(m_tvalid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
